// File: rtl/jtag_bus_master.sv
// Purpose : JTAG data register that launches single req/ack bus transactions and
//           returns busy/err/address/read data on the next Capture-DR.
// Latency : update_dr -> bus_req 1 tck; bus_ack -> busy low 1 tck; timeout after TIMEOUT busy cycles.
// Backpres: one transaction in flight; a launch while busy is dropped and flags err.
// Ports   : tck/reset_ clock and async active-low reset; tdi/bm_tdo serial in/out;
//           sel_ir, capture_dr, shift_dr, update_dr from the TAP; bus_req/bus_we/
//           bus_addr/bus_wdata/bus_ack/bus_rdata bus master side; busy status.
module jtag_bus_master #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 tck,
  input  logic                 reset_,
  input  logic                 tdi,
  output logic                 bm_tdo,
  input  logic                 sel_ir,
  input  logic                 capture_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [DATA_BITS-1:0] bus_wdata,
  input  logic                 bus_ack,
  input  logic [DATA_BITS-1:0] bus_rdata,
  output logic                 busy
);

  localparam int L  = 2 + ADDR_BITS + DATA_BITS;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [L-1:0]         sr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 err;
  logic [CW-1:0]        cnt;

  logic [1:0] cmd;
  logic       upd_sel;
  logic       is_xfer;
  logic       is_clr;
  logic       launch;
  logic       done_ack;
  logic       timed_out;
  logic       overrun;

  assign cmd     = sr[1:0];
  assign upd_sel = update_dr & sel_ir;
  assign is_xfer = upd_sel & ((cmd == 2'b01) | (cmd == 2'b10));
  assign is_clr  = upd_sel & (cmd == 2'b11);

  assign bm_tdo = sr[0];
  assign busy   = (state == BUSY);

  // Shift register: capture has priority over shift; everything holds when deselected.
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      sr <= '0;
    end else if (sel_ir) begin
      if (capture_dr)
        sr <= {rd_data, bus_addr, err, busy};
      else if (shift_dr)
        sr <= {tdi, sr[L-1:1]};
    end
  end

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    done_ack  = 1'b0;
    timed_out = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE: begin
        if (is_xfer) begin
          launch    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Ack takes precedence over a timeout expiring on the same edge.
        if (bus_ack) begin
          done_ack  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // Counter reaches TIMEOUT on this edge, i.e. TIMEOUT cycles spent waiting.
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
        overrun = is_xfer;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request, captured command fields and read data.
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_data   <= '0;
    end else begin
      bus_req <= (state_nxt == BUSY);
      if (launch) begin
        bus_we    <= cmd[1];
        bus_addr  <= sr[ADDR_BITS+1:2];
        bus_wdata <= sr[L-1:ADDR_BITS+2];
      end
      if (done_ack && !bus_we)
        rd_data <= bus_rdata;
    end
  end

  // Timeout counter saturates at TIMEOUT rather than wrapping.
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_)
      cnt <= '0;
    else if (launch)
      cnt <= '0;
    else if (state == BUSY && cnt != CW'(TIMEOUT))
      cnt <= cnt + 1'b1;
  end

  // Sticky error: setting events beat a coincident clear command.
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_)
      err <= 1'b0;
    else if (timed_out || overrun)
      err <= 1'b1;
    else if (is_clr)
      err <= 1'b0;
  end

endmodule

// File: tb/tb_jtag_bus_master.sv
// Purpose : directed bench for jtag_bus_master with scoreboarded capture words and bus requests.
// Latency : inputs change 1ns after posedge tck; outputs sampled on negedge tck.
// Backpres: monitors pop expected values from queues filled by the stimulus process.
module tb_jtag_bus_master;

  localparam int A  = 16;
  localparam int D  = 32;
  localparam int L  = 2 + A + D;
  localparam int TO = 255;

  logic         tck = 1'b0;
  logic         reset_ = 1'b0;
  logic         tdi = 1'b0;
  logic         sel_ir = 1'b0;
  logic         capture_dr = 1'b0;
  logic         shift_dr = 1'b0;
  logic         update_dr = 1'b0;
  logic         bus_ack = 1'b0;
  logic [D-1:0] bus_rdata = '0;
  logic         bm_tdo;
  logic         bus_req;
  logic         bus_we;
  logic [A-1:0] bus_addr;
  logic [D-1:0] bus_wdata;
  logic         busy;

  jtag_bus_master #(.ADDR_BITS(A), .DATA_BITS(D), .TIMEOUT(TO)) dut (
    .tck(tck), .reset_(reset_), .tdi(tdi), .bm_tdo(bm_tdo), .sel_ir(sel_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 tck = ~tck;

  int n_tests = 0;
  int n_fail  = 0;

  logic [L-1:0] cap_q[$];
  logic [A+D:0] bus_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [L-1:0] pack(input logic [1:0] lo, input logic [A-1:0] a,
                                        input logic [D-1:0] d);
    return {d, a, lo};
  endfunction

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  // Full DR scan: capture, shift L bits LSB first, update.
  task automatic scan(input logic [L-1:0] word, input logic [L-1:0] exp_cap);
    cap_q.push_back(exp_cap);
    sel_ir     = 1'b1;
    capture_dr = 1'b1;
    step();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    for (int i = 0; i < L; i++) begin
      tdi = word[i];
      step();
    end
    shift_dr  = 1'b0;
    tdi       = 1'b0;
    update_dr = 1'b1;
    step();
    update_dr = 1'b0;
  endtask

  // Capture monitor: collects bm_tdo during selected shifts and checks each full word.
  initial begin
    logic [L-1:0] got;
    int nb;
    got = '0;
    nb  = 0;
    forever begin
      @(negedge tck);
      if (sel_ir && shift_dr && !capture_dr) begin
        got[nb] = bm_tdo;
        nb++;
        if (nb == L) begin
          nb = 0;
          if (cap_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL capture_unexpected: got %h expected none", got);
          end else begin
            chk("capture_word", 64'(got), 64'(cap_q.pop_front()));
          end
        end
      end
    end
  end

  // Bus monitor: every rising bus_req must match the next expected transaction.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge tck);
      if (bus_req && !prev) begin
        if (bus_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bus_unexpected: got %h expected none", {bus_we, bus_addr, bus_wdata});
        end else begin
          chk("bus_txn", 64'({bus_we, bus_addr, bus_wdata}), 64'(bus_q.pop_front()));
        end
      end
      prev = bus_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;

    // Reset state
    #2;
    chk("rst_bus_req", 64'(bus_req), 64'(0));
    chk("rst_busy",    64'(busy),    64'(0));
    chk("rst_tdo",     64'(bm_tdo),  64'(0));
    step();
    step();
    reset_ = 1'b1;
    step();

    // Write with ack after 3 cycles
    bus_q.push_back({1'b1, 16'h1234, 32'hDEADBEEF});
    scan(pack(2'b10, 16'h1234, 32'hDEADBEEF), pack(2'b00, '0, '0));
    chk("wr_req_latency", 64'(bus_req), 64'(1));
    chk("wr_busy",        64'(busy),    64'(1));
    step();
    step();
    chk("wr_req_held", 64'(bus_req), 64'(1));
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("wr_req_drop", 64'(bus_req), 64'(0));
    chk("wr_busy_low", 64'(busy),    64'(0));

    // Read
    bus_q.push_back({1'b0, 16'h0040, 32'h0});
    scan(pack(2'b01, 16'h0040, '0), pack(2'b00, 16'h1234, '0));
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    chk("rd_busy_low", 64'(busy), 64'(0));

    // Timeout; this scan's capture checks the read result
    bus_q.push_back({1'b0, 16'h0077, 32'h0});
    scan(pack(2'b01, 16'h0077, '0), pack(2'b00, 16'h0040, 32'hCAFEF00D));
    cyc = 0;
    while (bus_req && cyc < 400) begin
      step();
      cyc++;
    end
    chk("timeout_cycles", 64'(cyc), 64'(TO));
    chk("timeout_busy",   64'(busy), 64'(0));
    scan(pack(2'b11, '0, '0), pack(2'b10, 16'h0077, 32'hCAFEF00D));

    // Overrun; capture also shows err cleared
    bus_q.push_back({1'b1, 16'h0100, 32'h11111111});
    scan(pack(2'b10, 16'h0100, 32'h11111111), pack(2'b00, 16'h0077, 32'hCAFEF00D));
    scan(pack(2'b10, 16'h0200, 32'h22222222), pack(2'b01, 16'h0100, 32'hCAFEF00D));
    chk("ovr_addr",  64'(bus_addr),  64'(16'h0100));
    chk("ovr_wdata", 64'(bus_wdata), 64'(32'h11111111));
    chk("ovr_req",   64'(bus_req),   64'(1));
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("ovr_busy_low", 64'(busy), 64'(0));

    // Ack while idle must not touch read data
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h55AA55AA;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    chk("idle_ack_req", 64'(bus_req), 64'(0));
    scan(pack(2'b11, '0, '0), pack(2'b10, 16'h0100, 32'hCAFEF00D));

    // Deselect: load a write word, scramble inputs while deselected, then relaunch it
    bus_q.push_back({1'b1, 16'h0300, 32'h33333333});
    scan(pack(2'b10, 16'h0300, 32'h33333333), pack(2'b00, 16'h0100, 32'hCAFEF00D));
    step();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    sel_ir  = 1'b0;
    capture_dr = 1'b1;
    step();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    bad = 0;
    for (int i = 0; i < L; i++) begin
      tdi = 1'($urandom_range(0, 1));
      step();
      if (bm_tdo !== 1'b0) bad++;
    end
    shift_dr = 1'b0;
    chk("desel_tdo_changes", 64'(bad), 64'(0));
    update_dr = 1'b1;
    step();
    update_dr = 1'b0;
    step();
    chk("desel_no_launch", 64'(bus_req), 64'(0));
    bus_q.push_back({1'b1, 16'h0300, 32'h33333333});
    sel_ir    = 1'b1;
    update_dr = 1'b1;
    step();
    chk("relaunch_req", 64'(bus_req), 64'(1));
    step();
    update_dr = 1'b0;

    // Reset mid-transaction with err set by the overrun above
    reset_ = 1'b0;
    #1;
    chk("rst_mid_req",   64'(bus_req),   64'(0));
    chk("rst_mid_busy",  64'(busy),      64'(0));
    chk("rst_mid_tdo",   64'(bm_tdo),    64'(0));
    chk("rst_mid_addr",  64'(bus_addr),  64'(0));
    chk("rst_mid_wdata", 64'(bus_wdata), 64'(0));
    chk("rst_mid_we",    64'(bus_we),    64'(0));
    step();
    reset_ = 1'b1;
    step();
    scan(pack(2'b00, '0, '0), pack(2'b00, '0, '0));
    step();
    step();

    chk("cap_q_drained", 64'(cap_q.size()), 64'(0));
    chk("bus_q_drained", 64'(bus_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
